// File: rtl/csa_slice_sequencer_if.sv
// rtl/csa_slice_sequencer_if.sv - operand/result handshake bundle for the slice sequencer
interface csa_slice_sequencer_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/csa_slice_sequencer.sv
// rtl/csa_slice_sequencer.sv - wide adder that walks one carry-select slice per clock
module csa_slice_sequencer #(
  parameter int SLICE_W    = 8,
  parameter int NUM_SLICES = 4
) (
  input logic                  clk,
  input logic                  rst,
  csa_slice_sequencer_if.slave bus
);
  localparam int W  = SLICE_W * NUM_SLICES;
  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [W-1:0]      op_a, op_b;
  logic [W-1:0]      sum_q;
  logic              cout_q;
  logic              out_valid_q;
  logic [SLICE_W-1:0] sa, sb;
  logic [SLICE_W:0]  s0, s1, ssel;
  logic              last;
  logic              accept;
  logic              out_fire;
  int                slice_lo;

  assign slice_lo = int'(idx) * SLICE_W;
  assign sa       = op_a[slice_lo +: SLICE_W];
  assign sb       = op_b[slice_lo +: SLICE_W];
  assign s0       = {1'b0, sa} + {1'b0, sb};
  assign s1       = s0 + {{SLICE_W{1'b0}}, 1'b1};
  assign ssel     = carry ? s1 : s0;
  assign last     = (idx == IW'(NUM_SLICES - 1));

  assign accept   = (state == IDLE) && bus.in_valid && !rst;
  assign out_fire = (state == DONE) && out_valid_q && bus.out_ready;

  // in_ready/busy are masked by rst so the producer never sees a ready during reset
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_q[slice_lo +: SLICE_W] <= ssel[SLICE_W-1:0];
          carry <= ssel[SLICE_W];
          idx   <= idx + IW'(1);
          if (last) begin
            cout_q      <= ssel[SLICE_W];
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_fire) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_slice_sequencer.sv
// tb/tb_csa_slice_sequencer.sv - scoreboard bench for csa_slice_sequencer
module tb_csa_slice_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  csa_slice_sequencer_if #(.W(32)) bus ();

  csa_slice_sequencer #(.SLICE_W(8), .NUM_SLICES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int accepts  = 0;
  int results  = 0;
  bit rnd_mode = 1'b0;
  logic [32:0] q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                      input logic [32:0] exp);
    int n;
    bus.in_valid = 1'b1;
    bus.a = xa;
    bus.b = xb;
    bus.cin = xc;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(n), 64'(0));
    end else begin
      q.push_back(exp);
      accepts++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a result is taken at the negedge preceding its handshake edge
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h expected=none", {bus.cout, bus.sum});
        end else begin
          exp = q.pop_front();
          check("result", 64'({bus.cout, bus.sum}), 64'(exp));
          results++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic rc;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
    vecs[3] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 33'h0_0100_0101};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_sum", 64'({bus.cout, bus.sum}), 64'(0));
    @(posedge clk);
    #1;

    // Latency of the first op: out_valid visible after the 4th edge past accept
    send(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].exp);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.out_valid && n < 20);
    check("latency", 64'(n), 64'(4));
    drain();

    for (int i = 1; i < 4; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);
      drain();
    end

    // Backpressure in DONE with a new operand set already offered
    bus.out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 33'h0_0000_0003);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a = 32'h0000_0005;
    bus.b = 32'h0000_0006;
    bus.cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_hold", 64'({bus.out_valid, bus.cout, bus.sum}), 64'({1'b1, 33'h0_0000_0003}));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(32'h0000_0005, 32'h0000_0006, 1'b1, 33'h0_0000_000C);
    drain();

    // Reset abort two RUN edges into an op, then rerun it
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);
    @(negedge clk);
    check("run_busy", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(q.pop_back());
    accepts--;
    @(negedge clk);
    check("abort_in_ready_rst", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);
    drain();

    // Random ops against the behavioural A+B+cin
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'b0, rc});
    end
    drain();
    rnd_mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    check("accepts_vs_results", 64'(results), 64'(accepts));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
